// File: rtl/mem_resp.sv
// -----------------------------------------------------------------------------
// mem_resp -- single-port data memory responder for a simple load/store core.
//
// Accepts one request at a time, performs a little-endian byte/half/word store
// or load against an internal DEPTH x 32-bit array, and returns one response.
// Misaligned, out-of-range and illegal-size requests answer with rsp_err=1 and
// leave the array untouched.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   req_valid     in   request present
//   req_ready     out  request can be accepted (IDLE only, not during reset)
//   req_we        in   1 = store, 0 = load
//   req_addr      in   byte address
//   req_wdata     in   store data, right-aligned
//   req_size      in   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   load zero-extends when 1, sign-extends when 0
//   rsp_valid     out  response present (RESP only)
//   rsp_ready     in   response consumed
//   rsp_rdata     out  formatted load data; 0 for stores, errors and outside RESP
//   rsp_err       out  request was rejected
// -----------------------------------------------------------------------------
module mem_resp #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Holds req_ready low during reset and until the first edge after release.
    logic ready_en_q, ready_en_d;

    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          size_err;
    logic          align_err;
    logic          range_err;
    logic          req_err;
    logic          mem_we;
    logic [AW-1:0] req_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_fmt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        accept    = req_valid && req_ready;
        size_err  = (req_size == 2'b11);
        align_err = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        // DEPTH is a power of two, so any set bit above the array span is out of range.
        range_err = |req_addr[31:AW+2];
        req_err   = size_err || align_err || range_err;
        req_idx   = req_addr[AW+1:2];
        mem_we    = accept && req_we && !req_err;
    end

    // Store lane steering: replicate the right-aligned data and pick byte enables.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = req_wdata;
        unique case (req_size)
            2'b00: begin
                wr_be    = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be    = 4'b1111;
                wr_lanes = req_wdata;
            end
            default: begin
                wr_be    = 4'b0000;
                wr_lanes = req_wdata;
            end
        endcase
    end

    // Array: no reset. Writes only happen on an accept edge, and req_ready is
    // forced low during reset, so reset can never produce a partial write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[req_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load formatting. Legal half/word loads have the low lane bits zero,
    // so one shift by the byte lane serves all three sizes.
    // ------------------------------------------------------------------
    always_comb begin
        rd_word  = mem[idx_q];
        rd_shift = rd_word >> {lane_q, 3'b000};
        unique case (size_q)
            2'b00:   rd_fmt = uns_q ? {24'h0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_fmt = uns_q ? {16'h0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_fmt = rd_shift;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ready_en_d = 1'b1;
        idx_d      = idx_q;
        lane_d     = lane_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d      = req_idx;
                    lane_d     = req_addr[1:0];
                    size_d     = req_size;
                    uns_d      = req_unsigned;
                    rsp_err_d  = req_err;
                    rsp_data_d = 32'h0;
                    state_d    = (req_we || req_err) ? StResp : StRead;
                end
            end
            StRead: begin
                rsp_data_d = rd_fmt;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == StIdle) && ready_en_q;
        rsp_valid = (state_q == StResp);
        rsp_rdata = rsp_valid ? rsp_data_q : 32'h0;
        rsp_err   = rsp_valid && rsp_err_q;
    end

endmodule

// File: tb/tb_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_mem_resp -- directed, table-driven bench for mem_resp (DEPTH = 64).
// -----------------------------------------------------------------------------
module tb_mem_resp;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mem_resp #(
        .DEPTH(64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d] got=%h want=%h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_we       = v.we;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
    endtask

    // Issue one request from IDLE, check latency and response, then retire it.
    task automatic do_req(input vec_t v, input int tag);
        drive(v);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (v.lat == 2) begin
            chk("read_no_rsp_yet", tag, {31'h0, rsp_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        chk("rsp_valid", tag, {31'h0, rsp_valid}, 32'h1);
        chk("rsp_err", tag, {31'h0, rsp_err}, {31'h0, v.exp_err});
        chk("rsp_rdata", tag, rsp_rdata, v.exp_rdata);
        chk("busy_ready", tag, {31'h0, req_ready}, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_valid", tag, {31'h0, rsp_valid}, 32'h0);
        chk("idle_ready", tag, {31'h0, req_ready}, 32'h1);
        chk("idle_rdata", tag, rsp_rdata, 32'h0);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, input logic err,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.size      = size;
        v.uns       = uns;
        v.exp_err   = err;
        v.exp_rdata = rdata;
        v.lat       = lat;
        return v;
    endfunction

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b0;

        //             we    addr           wdata          size   uns   err   rdata         lat
        vecs.push_back(mk(1'b1, 32'h10,       32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF, 2));
        vecs.push_back(mk(1'b1, 32'h10,       32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b1, 32'h13,       32'hABCDEF80, 2'b00, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h13,       32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFF80, 2));
        vecs.push_back(mk(1'b0, 32'h13,       32'h0,        2'b00, 1'b1, 1'b0, 32'h00000080, 2));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 32'h80223344, 2));
        vecs.push_back(mk(1'b0, 32'h12,       32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFF8022, 2));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b01, 1'b1, 1'b0, 32'h00003344, 2));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b00, 1'b0, 1'b0, 32'h00000044, 2));
        vecs.push_back(mk(1'b0, 32'h11,       32'h0,        2'b01, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h100,      32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b1, 32'h10,       32'hFFFFFFFF, 2'b11, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 32'h80223344, 2));
        vecs.push_back(mk(1'b1, 32'h14,       32'hA5A5A5A5, 2'b10, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b1, 32'h16,       32'hFFFF1234, 2'b01, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h14,       32'h0,        2'b10, 1'b0, 1'b0, 32'h1234A5A5, 2));
        vecs.push_back(mk(1'b1, 32'h12,       32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b1, 32'h110,      32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b1, 32'h80000010, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'h10,       32'h0,        2'b10, 1'b0, 1'b0, 32'h80223344, 2));
        vecs.push_back(mk(1'b1, 32'hFC,       32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 32'h0,        1));
        vecs.push_back(mk(1'b0, 32'hFF,       32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFCA, 2));
        vecs.push_back(mk(1'b0, 32'hFE,       32'h0,        2'b01, 1'b1, 1'b0, 32'h0000CAFE, 2));
        vecs.push_back(mk(1'b0, 32'hFC,       32'h0,        2'b10, 1'b0, 1'b0, 32'hCAFEF00D, 2));
        vecs.push_back(mk(1'b0, 32'h11,       32'h0,        2'b00, 1'b1, 1'b0, 32'h00000033, 2));

        // Reset state: outputs low and not ready while reset is held.
        #1;
        chk("rst_valid", 0, {31'h0, rsp_valid}, 32'h0);
        chk("rst_ready", 0, {31'h0, req_ready}, 32'h0);
        chk("rst_rdata", 0, rsp_rdata, 32'h0);
        chk("rst_err", 0, {31'h0, rsp_err}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready_pre_edge", 0, {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_ready_post_edge", 0, {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i], i);
        end

        // Stalled response: load @0x10, hold rsp_ready low while a store is offered.
        drive(mk(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 2));
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1));
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 100 + c, {31'h0, rsp_valid}, 32'h1);
            chk("stall_rdata", 100 + c, rsp_rdata, 32'h80223344);
            chk("stall_err", 100 + c, {31'h0, rsp_err}, 32'h0);
            chk("stall_ready", 100 + c, {31'h0, req_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("stall_release", 105, {31'h0, rsp_valid}, 32'h0);
        do_req(mk(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h80223344, 2), 106);

        // Reset while in READ: response dropped immediately, memory kept.
        drive(mk(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 2));
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid_read_valid", 200, {31'h0, rsp_valid}, 32'h0);
        chk("mid_read_ready", 200, {31'h0, req_ready}, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 201, {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst_ready", 201, {31'h0, req_ready}, 32'h0);
        chk("mid_rst_rdata", 201, rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_valid", 202, {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 203, {31'h0, req_ready}, 32'h1);
        chk("post_rst_valid", 203, {31'h0, rsp_valid}, 32'h0);
        do_req(mk(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 32'h80223344, 2), 204);
        do_req(mk(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 1'b0, 32'h1234A5A5, 2), 205);
        do_req(mk(1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCAFEF00D, 2), 206);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
